// File: rtl/mem_line_responder_if.sv
// Word-granular memory bus between the line responder (master) and the
// system memory bus (slave). One request in flight at a time; read data
// comes back on a separate valid strobe.
interface mem_line_responder_if #(
  parameter int WORD_WIDTH     = 32,
  parameter int BUS_ADDR_WIDTH = 28
);
  logic                      busValid;
  logic                      busWrite;
  logic [BUS_ADDR_WIDTH-1:0] busAddr;
  logic [WORD_WIDTH-1:0]     busWriteData;
  logic                      busReady;
  logic                      busReadDataValid;
  logic [WORD_WIDTH-1:0]     busReadData;

  modport master (
    output busValid, busWrite, busAddr, busWriteData,
    input  busReady, busReadDataValid, busReadData
  );

  modport slave (
    input  busValid, busWrite, busAddr, busWriteData,
    output busReady, busReadDataValid, busReadData
  );
endinterface

// File: rtl/mem_line_responder.sv
// Line-to-word memory responder: takes one cache-line read or write from the
// replacer, walks it out as ascending word beats on the word bus, reassembles
// read words into the line register and pulses the matching done for a cycle.
// All bus outputs are registered, so nothing on mem* reaches the bus
// combinationally.
module mem_line_responder #(
  parameter int LINE_WIDTH     = 128,
  parameter int WORD_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 26
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MEM_ADDR_WIDTH-1:0] i_memAddr,
  input  logic                      i_memReadEnable,
  input  logic                      i_memWriteEnable,
  input  logic [LINE_WIDTH-1:0]     i_memWriteValue,
  output logic                      o_memReadDone,
  output logic                      o_memWriteDone,
  output logic [LINE_WIDTH-1:0]     o_memReadValue,
  mem_line_responder_if.master      bus
);
  localparam int BEATS          = LINE_WIDTH / WORD_WIDTH;
  localparam int BEAT_WIDTH     = $clog2(BEATS);
  localparam int BUS_ADDR_WIDTH = MEM_ADDR_WIDTH + BEAT_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE_BEAT,
    S_READ_REQ,
    S_READ_WAIT,
    S_DONE
  } state_t;

  state_t                    r_State;
  logic [MEM_ADDR_WIDTH-1:0] r_Addr;
  logic [LINE_WIDTH-1:0]     r_Line;
  logic [BEAT_WIDTH-1:0]     r_Beat;
  logic                      r_BusValid;
  logic                      r_BusWrite;
  logic [BUS_ADDR_WIDTH-1:0] r_BusAddr;
  logic [WORD_WIDTH-1:0]     r_BusWriteData;
  logic                      r_ReadDone;
  logic                      r_WriteDone;

  logic [BEAT_WIDTH-1:0]     w_NextBeat;
  logic                      w_LastBeat;

  assign w_NextBeat = r_Beat + BEAT_WIDTH'(1);
  assign w_LastBeat = (r_Beat == BEAT_WIDTH'(BEATS - 1));

  // Sequencer: state, beat counter, line buffer and every registered output.
  // Bus outputs are loaded on the transition into a requesting state so the
  // request appears the cycle after the decision, and are zeroed whenever the
  // request drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_State        <= S_IDLE;
      r_Addr         <= '0;
      r_Line         <= '0;
      r_Beat         <= '0;
      r_BusValid     <= 1'b0;
      r_BusWrite     <= 1'b0;
      r_BusAddr      <= '0;
      r_BusWriteData <= '0;
      r_ReadDone     <= 1'b0;
      r_WriteDone    <= 1'b0;
    end else begin
      r_ReadDone  <= 1'b0;
      r_WriteDone <= 1'b0;
      case (r_State)
        S_IDLE: begin
          // Write has priority when both enables are up.
          if (i_memWriteEnable) begin
            r_Addr         <= i_memAddr;
            r_Line         <= i_memWriteValue;
            r_Beat         <= '0;
            r_BusValid     <= 1'b1;
            r_BusWrite     <= 1'b1;
            r_BusAddr      <= {i_memAddr, BEAT_WIDTH'(0)};
            r_BusWriteData <= i_memWriteValue[WORD_WIDTH-1:0];
            r_State        <= S_WRITE_BEAT;
          end else if (i_memReadEnable) begin
            r_Addr         <= i_memAddr;
            r_Beat         <= '0;
            r_BusValid     <= 1'b1;
            r_BusWrite     <= 1'b0;
            r_BusAddr      <= {i_memAddr, BEAT_WIDTH'(0)};
            r_BusWriteData <= '0;
            r_State        <= S_READ_REQ;
          end
        end
        S_WRITE_BEAT: begin
          if (bus.busReady) begin
            if (w_LastBeat) begin
              r_BusValid     <= 1'b0;
              r_BusWrite     <= 1'b0;
              r_BusAddr      <= '0;
              r_BusWriteData <= '0;
              r_WriteDone    <= 1'b1;
              r_State        <= S_DONE;
            end else begin
              r_Beat         <= w_NextBeat;
              r_BusAddr      <= {r_Addr, w_NextBeat};
              r_BusWriteData <= r_Line[w_NextBeat*WORD_WIDTH +: WORD_WIDTH];
            end
          end
        end
        S_READ_REQ: begin
          // Request accepted: drop valid and wait for the single outstanding word.
          if (bus.busReady) begin
            r_BusValid <= 1'b0;
            r_BusAddr  <= '0;
            r_State    <= S_READ_WAIT;
          end
        end
        S_READ_WAIT: begin
          if (bus.busReadDataValid) begin
            r_Line[r_Beat*WORD_WIDTH +: WORD_WIDTH] <= bus.busReadData;
            if (w_LastBeat) begin
              r_ReadDone <= 1'b1;
              r_State    <= S_DONE;
            end else begin
              r_Beat     <= w_NextBeat;
              r_BusValid <= 1'b1;
              r_BusAddr  <= {r_Addr, w_NextBeat};
              r_State    <= S_READ_REQ;
            end
          end
        end
        S_DONE: begin
          // Done pulse is already on the outputs this cycle.
          r_State <= S_IDLE;
        end
        default: begin
          r_State <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busValid     = r_BusValid;
  assign bus.busWrite     = r_BusWrite;
  assign bus.busAddr      = r_BusAddr;
  assign bus.busWriteData = r_BusWriteData;
  assign o_memReadDone    = r_ReadDone;
  assign o_memWriteDone   = r_WriteDone;
  assign o_memReadValue   = r_Line;
endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder: a word-bus memory model answers the DUT with
// random ready and latency; a line-level reference memory predicts each done,
// pushed to a scoreboard at issue and popped by an independent monitor.
module tb_mem_line_responder;
  logic         clk = 1'b0;
  logic         rst;
  logic [25:0]  memAddr;
  logic         rdEn, wrEn;
  logic [127:0] wval;
  logic         rdDone, wrDone;
  logic [127:0] rdVal;

  int checks = 0;
  int errors = 0;

  mem_line_responder_if #(.WORD_WIDTH(32), .BUS_ADDR_WIDTH(28)) bus_if ();

  mem_line_responder #(.LINE_WIDTH(128), .WORD_WIDTH(32), .MEM_ADDR_WIDTH(26)) dut (
    .clk(clk), .rst(rst),
    .i_memAddr(memAddr), .i_memReadEnable(rdEn), .i_memWriteEnable(wrEn),
    .i_memWriteValue(wval),
    .o_memReadDone(rdDone), .o_memWriteDone(wrDone), .o_memReadValue(rdVal),
    .bus(bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model (line granular) ----------------
  typedef struct { bit wr; logic [127:0] data; } exp_t;
  exp_t sb_q[$];
  logic [127:0] ref_mem [logic [25:0]];
  logic [31:0]  bus_mem [logic [27:0]];

  function automatic logic [31:0] init_word(input logic [27:0] ba);
    return (32'(ba) * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [127:0] ref_line(input logic [25:0] a);
    logic [127:0] l;
    if (ref_mem.exists(a)) return ref_mem[a];
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = init_word({a, 2'(i)});
    return l;
  endfunction

  // ---------------- word bus memory model ----------------
  int ready_prob = 100, lat_min = 1, lat_max = 1, stall_left = 0;
  bit junk_en = 0;

  initial begin
    bit pend = 0;
    int cnt = 0;
    logic [31:0] pdata = '0;
    bit rdy;
    bus_if.busReady = 1'b0;
    bus_if.busReadDataValid = 1'b0;
    bus_if.busReadData = '0;
    forever begin
      @(negedge clk);
      bus_if.busReadDataValid = 1'b0;
      bus_if.busReadData = '0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          bus_if.busReadDataValid = 1'b1;
          bus_if.busReadData = pdata;
          pend = 0;
        end
      end else if (junk_en && $urandom_range(0, 3) == 0) begin
        bus_if.busReadDataValid = 1'b1;
        bus_if.busReadData = $urandom;
      end
      rdy = ($urandom_range(1, 100) <= ready_prob);
      if (stall_left > 0 && bus_if.busValid && bus_if.busWrite && bus_if.busAddr[1:0] == 2'd2) begin
        rdy = 0;
        stall_left--;
      end
      bus_if.busReady = rdy;
      if (bus_if.busValid && rdy && !rst) begin
        if (bus_if.busWrite) bus_mem[bus_if.busAddr] = bus_if.busWriteData;
        else begin
          pend = 1;
          cnt = $urandom_range(lat_min, lat_max);
          pdata = bus_mem.exists(bus_if.busAddr) ? bus_mem[bus_if.busAddr] : init_word(bus_if.busAddr);
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit pv = 0, pr = 0, pw = 0;
    logic [27:0] pa = '0;
    logic [31:0] pd = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) pv = 0;
      else begin
        if (rdDone && wrDone) check("dual_done", 2'b11, 2'b01);
        if (rdDone || wrDone) begin
          if (sb_q.size() == 0) check("unexpected_done", {rdDone, wrDone}, 2'b00);
          else begin
            e = sb_q.pop_front();
            check("done_op_is_write", wrDone, e.wr);
            if (!e.wr) check("read_line", rdVal, e.data);
          end
        end
        if (!bus_if.busValid)
          check("bus_idle_zero", {bus_if.busWrite, bus_if.busAddr, bus_if.busWriteData}, '0);
        if (pv && !pr)
          check("stall_hold", {bus_if.busValid, bus_if.busWrite, bus_if.busAddr, bus_if.busWriteData},
                {1'b1, pw, pa, pd});
        pv = bus_if.busValid; pr = bus_if.busReady; pw = bus_if.busWrite;
        pa = bus_if.busAddr;  pd = bus_if.busWriteData;
      end
    end
  end

  // ---------------- requester ----------------
  // Called at posedge+1; cycle 0 is the accept cycle.
  task automatic run_op(input bit wr, input bit rd, input logic [25:0] a, input logic [127:0] v,
                        output int done_cyc, output logic [31:0] vmask);
    exp_t e;
    e.wr = wr;
    e.data = wr ? '0 : ref_line(a);
    if (wr) ref_mem[a] = v;
    sb_q.push_back(e);
    memAddr = a; wval = v; wrEn = wr; rdEn = rd;
    done_cyc = -1; vmask = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (c < 32 && bus_if.busValid) vmask[c] = 1'b1;
      if (rdDone || wrDone) begin done_cyc = c; break; end
    end
    check("op_completes", done_cyc >= 0, 1'b1);
    check("first_valid_cycle1", vmask[1:0], 2'b10);
    @(posedge clk); #1;
    wrEn = 0; rdEn = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    logic [31:0] vm;
    logic [127:0] lineA, v;
    bit found;
    rst = 1; rdEn = 0; wrEn = 0; memAddr = '0; wval = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {rdDone, wrDone, bus_if.busValid, bus_if.busWrite, bus_if.busAddr, bus_if.busWriteData}, '0);
    check("reset_line", rdVal, '0);
    @(posedge clk); #1;
    rst = 0;

    // Write line 5, ready always high.
    run_op(1, 0, 26'h5, 128'h33333333_22222222_11111111_00000000, dc, vm);
    check("wr_done_cycle", dc, 5);
    check("wr_valid_cycles", vm, 32'h0000_001E);
    for (int i = 0; i < 4; i++)
      check("wr_bus_word", bus_mem.exists(28'h14 + 28'(i)) ? bus_mem[28'h14 + 28'(i)] : 32'hDEAD_BEEF,
            32'(i) * 32'h1111_1111);

    // Memory now holds A0..A3 for line 5; read back with latency 1.
    for (int i = 0; i < 4; i++) begin
      bus_mem[28'h14 + 28'(i)] = 32'hA0 + 32'(i);
      lineA[i*32 +: 32] = 32'hA0 + 32'(i);
    end
    ref_mem[26'h5] = lineA;
    run_op(0, 1, 26'h5, '0, dc, vm);
    check("rd_done_cycle", dc, 9);
    check("rd_valid_cycles", vm, 32'h0000_00AA);
    repeat (2) @(negedge clk);
    check("rd_value_held", rdVal, 128'h000000A3_000000A2_000000A1_000000A0);
    @(posedge clk); #1;

    // Stall beat 2 of a write for three cycles.
    stall_left = 3;
    run_op(1, 0, 26'h9, {$urandom, $urandom, $urandom, $urandom}, dc, vm);
    check("stall_done_cycle", dc, 8);
    check("stall_valid_cycles", vm, 32'h0000_00FE);

    // Both enables: write wins; immediately read it back (back-to-back).
    run_op(1, 1, 26'hA, {$urandom, $urandom, $urandom, $urandom}, dc, vm);
    check("both_done_cycle", dc, 5);
    lat_min = 2; lat_max = 2;
    run_op(0, 1, 26'hA, '0, dc, vm);
    check("rd_lat2_done_cycle", dc, 13);

    // Reset during ReadWait of beat 1; late data must be ignored.
    lat_min = 6; lat_max = 6;
    memAddr = 26'h5; rdEn = 1; found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk); #1;
      if (bus_if.busValid && bus_if.busReady && bus_if.busAddr[1:0] == 2'd1) found = 1;
    end
    check("reset_test_reached_beat1", found, 1'b1);
    @(posedge clk); #1;
    rst = 1; rdEn = 0;
    @(posedge clk); #1;
    rst = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("abort_outputs_zero", {rdDone, wrDone, bus_if.busValid, bus_if.busWrite, bus_if.busAddr, bus_if.busWriteData}, '0);
      check("abort_line_zero", rdVal, '0);
    end
    @(posedge clk); #1;
    lat_min = 1; lat_max = 1;
    run_op(0, 1, 26'h5, '0, dc, vm);
    check("post_reset_rd_done_cycle", dc, 9);

    // Randomized traffic.
    ready_prob = 60; lat_min = 1; lat_max = 4; junk_en = 1;
    for (int n = 0; n < 40; n++) begin
      int kind;
      logic [25:0] a;
      kind = $urandom_range(0, 2);
      a = 26'h100 + 26'($urandom_range(0, 7));
      v = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      run_op(kind != 1, kind != 0, a, v, dc, vm);
    end
    junk_en = 0;
    repeat (5) @(posedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
